debug_rx_ctrl: RTL and testbench
================================

Name: debug_rx_ctrl

Overview:
Parametrised successor of DebuggerRx. Decodes byte-wide debug commands from the UART receive FIFO and drives the pipeline's gated clock and reset. It adds multi-step execution, a PC breakpoint, a run-cycle watchdog and a stop-reason code on top of single-step, run and reset. Sits between the uart rx side, Pipeline/EndProgramDetector and the debug transmitter, which consumes send_data/data_sent.

Parameters:
CMD_W, 8, width of r_data (one UART byte)
PC_W, 10, width of pc_in and the breakpoint register
RUN_LIMIT_W, 16, watchdog counter width; RUN aborts after 2^RUN_LIMIT_W-1 pulses
RST_PULSES, 2, pipeline_clk pulses issued with pipeline_reset high per reset sequence (>=1)

Ports:
clk  in  1  system clock
global_reset  in  1  synchronous, active-high reset
r_data  in  CMD_W  byte at head of uart rx FIFO
rx_empty  in  1  rx FIFO empty
rd_uart  out  1  one-cycle pop of rx FIFO
program_finished  in  1  from EndProgramDetector
pc_in  in  PC_W  PC_IFID from pipeline
pipeline_clk  out  1  gated pipeline clock, registered
pipeline_reset  out  1  pipeline reset, registered
send_data  out  1  one-cycle request to transmitter
data_sent  in  1  transmitter done (level or pulse)
stop_reason  out  2  0 step/reset done, 1 program finished, 2 breakpoint, 3 watchdog
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: rd_uart=0, pipeline_clk=0, pipeline_reset=1, send_data=0, stop_reason=0, busy=1, bp_en=0, bp_pc=0. All counters are 0.
- After global_reset falls, run an automatic reset sequence (below) with no send_data, then go to IDLE.
- One pulse = pipeline_clk high for 1 clk, then low for 1 clk (states PULSE_HI, PULSE_LO).
- Byte fetch: in IDLE/ARG states, if rx_empty=0 at cycle t, latch r_data at edge t and pulse rd_uart in t+1. The next byte is not sampled before t+2. rx_empty is ignored in all other states, so bytes wait in the FIFO.
- Commands, decoded in the cycle after rd_uart:
  - 0x01 STEP: 1 pulse.
  - 0x02 RUN: pulse until a stop condition.
  - 0x03 RESET: reset sequence.
  - 0x04 STEP_N: next byte N gives N pulses. N=0 gives no pulse, straight to SEND.
  - 0x05 SET_BP: next byte is PC[7:0], following byte is PC[PC_W-1:8] (low PC_W-8 bits used). Sets bp_en=1, then SEND.
  - 0x06 CLR_BP: bp_en=0, then SEND.
  - Any other byte: discarded, return to IDLE, no send.
- Reset sequence: pipeline_reset=1 for RST_PULSES pulses. Drop pipeline_reset in the cycle after the last PULSE_LO.
- Stop evaluation in each PULSE_LO, in priority order:
  1. program_finished=1 gives reason 1.
  2. bp_en and pc_in==bp_pc gives reason 2 (RUN and STEP_N only).
  3. Watchdog count == 2^RUN_LIMIT_W-1 gives reason 3 (RUN only).
  4. Step count exhausted gives reason 0.
  - On a stop, go to SEND. Otherwise go to PULSE_HI next cycle.
- program_finished already high at RUN start: one pulse is still issued, then stop reason 1.
- SEND: send_data=1 for exactly one cycle, stop_reason valid from this cycle until next SEND. Then WAIT_SENT until data_sent=1, then IDLE.
- data_sent high outside WAIT_SENT is ignored.
- global_reset mid-operation: immediate abort to reset values. The automatic reset sequence follows; no partial send.
- The watchdog counter and step counter clear at each command start.

Test Plan:
- Power-up: global_reset high 2 cycles then low -> pipeline_reset=1 through 2 pulses (4 clk), then 0. send_data never asserted; busy falls to 0.
- STEP: rx_empty=0, r_data=0x01 at cycle t -> rd_uart at t+1, pipeline_clk high t+2, low t+3, send_data t+4 with stop_reason=0. busy stays high until data_sent=1.
- STEP_N: bytes 0x04, 0x05 -> exactly 5 pipeline_clk rising edges, then one send_data. With bytes 0x04, 0x00 -> 0 edges, then send_data.
- Breakpoint: SET_BP 0x05,0x0C,0x00; then RUN with pc_in incrementing by 1 per pulse from 0 -> stops in the PULSE_LO where pc_in=12, stop_reason=2. CLR_BP then RUN -> continues past 12.
- RUN end/watchdog: program_finished rises after pulse 7 -> stop_reason=1 after 7 pulses. With RUN_LIMIT_W=4 and no finish -> stops after 15 pulses, stop_reason=3.
- Abort/robustness: global_reset during RUN -> outputs return to reset values next cycle, reset sequence follows. Unknown byte 0xAA -> rd_uart pulse only, no send_data. rx_empty=0 while busy -> no rd_uart.

Source files
------------

// File: rtl/debug_rx_ctrl.sv
// debug_rx_ctrl
//   Decodes byte-wide debug commands popped from the UART rx FIFO and drives
//   the pipeline's gated clock and reset. Supports single step, N steps, free
//   run, pipeline reset, and setting/clearing a PC breakpoint. Every command
//   that finishes normally raises send_data for one cycle with a stop-reason
//   code, then waits for the transmitter to acknowledge with data_sent.
//
// Ports
//   clk              system clock
//   global_reset     synchronous active-high reset
//   r_data           byte at the head of the rx FIFO
//   rx_empty         rx FIFO empty flag
//   rd_uart          one-cycle FIFO pop (registered)
//   program_finished end-of-program flag from the pipeline
//   pc_in            current PC (IF/ID) from the pipeline
//   pipeline_clk     gated pipeline clock (registered)
//   pipeline_reset   pipeline reset (registered)
//   send_data        one-cycle request to the debug transmitter (registered)
//   data_sent        transmitter done; only observed while waiting for it
//   stop_reason      0 step/reset done, 1 finished, 2 breakpoint, 3 watchdog
//   busy             high whenever the controller is not idle (registered)
module debug_rx_ctrl #(
  parameter int CMD_W       = 8,
  parameter int PC_W        = 10,
  parameter int RUN_LIMIT_W = 16,
  parameter int RST_PULSES  = 2
) (
  input  logic             clk,
  input  logic             global_reset,
  input  logic [CMD_W-1:0] r_data,
  input  logic             rx_empty,
  output logic             rd_uart,
  input  logic             program_finished,
  input  logic [PC_W-1:0]  pc_in,
  output logic             pipeline_clk,
  output logic             pipeline_reset,
  output logic             send_data,
  input  logic             data_sent,
  output logic [1:0]       stop_reason,
  output logic             busy
);

  // The step counter must hold both an 8-bit step count and RST_PULSES.
  localparam int RST_CW  = $clog2(RST_PULSES + 1);
  localparam int CNT_W   = (CMD_W > RST_CW) ? CMD_W : RST_CW;
  localparam int BP_HI_W = PC_W - 8;

  localparam logic [CMD_W-1:0] CMD_STEP   = CMD_W'(8'h01);
  localparam logic [CMD_W-1:0] CMD_RUN    = CMD_W'(8'h02);
  localparam logic [CMD_W-1:0] CMD_RESET  = CMD_W'(8'h03);
  localparam logic [CMD_W-1:0] CMD_STEP_N = CMD_W'(8'h04);
  localparam logic [CMD_W-1:0] CMD_SET_BP = CMD_W'(8'h05);
  localparam logic [CMD_W-1:0] CMD_CLR_BP = CMD_W'(8'h06);

  localparam logic [1:0] RSN_DONE   = 2'd0;
  localparam logic [1:0] RSN_FINISH = 2'd1;
  localparam logic [1:0] RSN_BP     = 2'd2;
  localparam logic [1:0] RSN_WDOG   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_GOT,
    S_RST_INIT,
    S_PULSE_HI,
    S_PULSE_LO,
    S_SEND,
    S_WAIT_SENT
  } state_t;

  typedef enum logic [2:0] {
    M_AUTO_RST,
    M_CMD_RST,
    M_STEP,
    M_STEP_N,
    M_RUN
  } mode_t;

  // What the byte held in byte_r means when it is processed in S_GOT.
  typedef enum logic [1:0] {
    P_CMD,
    P_N,
    P_BP_LO,
    P_BP_HI
  } phase_t;

  state_t                 state_r, state_s;
  mode_t                  mode_r, mode_s;
  phase_t                 phase_r, phase_s;
  logic [CMD_W-1:0]       byte_r, byte_s;
  logic [7:0]             bp_lo_r, bp_lo_s;
  logic [PC_W-1:0]        bp_pc_r, bp_pc_s;
  logic                   bp_en_r, bp_en_s;
  logic [CNT_W-1:0]       step_cnt_r, step_cnt_s;
  logic [CNT_W-1:0]       step_tgt_r, step_tgt_s;
  logic [RUN_LIMIT_W-1:0] wd_cnt_r, wd_cnt_s;
  logic [1:0]             reason_s;
  logic                   preset_s;

  logic is_rst_s;
  logic cnt_done_s;
  logic bp_hit_s;
  logic wd_max_s;

  // step_cnt counts pulses already issued, so in PULSE_LO it includes the
  // pulse that just completed.
  assign is_rst_s   = (mode_r == M_AUTO_RST) || (mode_r == M_CMD_RST);
  assign cnt_done_s = (step_cnt_r == step_tgt_r);
  assign bp_hit_s   = bp_en_r && (pc_in == bp_pc_r) &&
                      ((mode_r == M_RUN) || (mode_r == M_STEP_N));
  assign wd_max_s   = &wd_cnt_r;

  // Next-state and next-datapath logic for the command FSM.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    phase_s    = phase_r;
    byte_s     = byte_r;
    bp_lo_s    = bp_lo_r;
    bp_pc_s    = bp_pc_r;
    bp_en_s    = bp_en_r;
    step_cnt_s = step_cnt_r;
    step_tgt_s = step_tgt_r;
    wd_cnt_s   = wd_cnt_r;
    reason_s   = stop_reason;
    preset_s   = pipeline_reset;

    case (state_r)
      S_IDLE: begin
        if (!rx_empty) begin
          byte_s  = r_data;
          phase_s = P_CMD;
          state_s = S_GOT;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_ARG: begin
        if (!rx_empty) begin
          byte_s  = r_data;
          state_s = S_GOT;
        end else begin
          state_s = S_ARG;
        end
      end

      // rd_uart is high in this state; the latched byte is acted on here.
      S_GOT: begin
        case (phase_r)
          P_CMD: begin
            case (byte_r)
              CMD_STEP: begin
                mode_s     = M_STEP;
                step_tgt_s = CNT_W'(1);
                step_cnt_s = {CNT_W{1'b0}};
                wd_cnt_s   = {RUN_LIMIT_W{1'b0}};
                state_s    = S_PULSE_HI;
              end
              CMD_RUN: begin
                mode_s     = M_RUN;
                step_cnt_s = {CNT_W{1'b0}};
                wd_cnt_s   = {RUN_LIMIT_W{1'b0}};
                state_s    = S_PULSE_HI;
              end
              CMD_RESET: begin
                mode_s     = M_CMD_RST;
                step_tgt_s = CNT_W'(RST_PULSES);
                step_cnt_s = {CNT_W{1'b0}};
                wd_cnt_s   = {RUN_LIMIT_W{1'b0}};
                preset_s   = 1'b1;
                state_s    = S_RST_INIT;
              end
              CMD_STEP_N: begin
                phase_s = P_N;
                state_s = S_ARG;
              end
              CMD_SET_BP: begin
                phase_s = P_BP_LO;
                state_s = S_ARG;
              end
              CMD_CLR_BP: begin
                bp_en_s  = 1'b0;
                reason_s = RSN_DONE;
                state_s  = S_SEND;
              end
              default: begin
                state_s = S_IDLE;
              end
            endcase
          end

          P_N: begin
            if (byte_r == {CMD_W{1'b0}}) begin
              reason_s = RSN_DONE;
              state_s  = S_SEND;
            end else begin
              mode_s     = M_STEP_N;
              step_tgt_s = CNT_W'(byte_r);
              step_cnt_s = {CNT_W{1'b0}};
              wd_cnt_s   = {RUN_LIMIT_W{1'b0}};
              state_s    = S_PULSE_HI;
            end
          end

          // Low PC byte is staged so a half-written breakpoint never matches.
          P_BP_LO: begin
            bp_lo_s = byte_r[7:0];
            phase_s = P_BP_HI;
            state_s = S_ARG;
          end

          P_BP_HI: begin
            bp_pc_s  = {byte_r[BP_HI_W-1:0], bp_lo_r};
            bp_en_s  = 1'b1;
            reason_s = RSN_DONE;
            state_s  = S_SEND;
          end

          default: begin
            state_s = S_IDLE;
          end
        endcase
      end

      // Holds the clock low for a cycle so pipeline_reset is settled before
      // the first reset pulse rises.
      S_RST_INIT: begin
        state_s = S_PULSE_HI;
      end

      S_PULSE_HI: begin
        step_cnt_s = step_cnt_r + CNT_W'(1);
        wd_cnt_s   = wd_cnt_r + RUN_LIMIT_W'(1);
        state_s    = S_PULSE_LO;
      end

      // Stop evaluation; the reset sequence only looks at its pulse count
      // because the finished flag may be stale from the previous program.
      S_PULSE_LO: begin
        if (is_rst_s) begin
          if (cnt_done_s) begin
            preset_s = 1'b0;
            if (mode_r == M_CMD_RST) begin
              reason_s = RSN_DONE;
              state_s  = S_SEND;
            end else begin
              state_s = S_IDLE;
            end
          end else begin
            state_s = S_PULSE_HI;
          end
        end else if (program_finished) begin
          reason_s = RSN_FINISH;
          state_s  = S_SEND;
        end else if (bp_hit_s) begin
          reason_s = RSN_BP;
          state_s  = S_SEND;
        end else if ((mode_r == M_RUN) && wd_max_s) begin
          reason_s = RSN_WDOG;
          state_s  = S_SEND;
        end else if ((mode_r != M_RUN) && cnt_done_s) begin
          reason_s = RSN_DONE;
          state_s  = S_SEND;
        end else begin
          state_s = S_PULSE_HI;
        end
      end

      S_SEND: begin
        state_s = S_WAIT_SENT;
      end

      S_WAIT_SENT: begin
        if (data_sent) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_SENT;
        end
      end

      // An illegal encoding re-runs the automatic reset sequence.
      default: begin
        mode_s     = M_AUTO_RST;
        step_tgt_s = CNT_W'(RST_PULSES);
        step_cnt_s = {CNT_W{1'b0}};
        wd_cnt_s   = {RUN_LIMIT_W{1'b0}};
        preset_s   = 1'b1;
        state_s    = S_RST_INIT;
      end
    endcase
  end

  // State, datapath and registered outputs; outputs are decoded from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_r        <= S_RST_INIT;
      mode_r         <= M_AUTO_RST;
      phase_r        <= P_CMD;
      byte_r         <= {CMD_W{1'b0}};
      bp_lo_r        <= 8'h00;
      bp_pc_r        <= {PC_W{1'b0}};
      bp_en_r        <= 1'b0;
      step_cnt_r     <= {CNT_W{1'b0}};
      step_tgt_r     <= CNT_W'(RST_PULSES);
      wd_cnt_r       <= {RUN_LIMIT_W{1'b0}};
      rd_uart        <= 1'b0;
      pipeline_clk   <= 1'b0;
      pipeline_reset <= 1'b1;
      send_data      <= 1'b0;
      stop_reason    <= 2'd0;
      busy           <= 1'b1;
    end else begin
      state_r        <= state_s;
      mode_r         <= mode_s;
      phase_r        <= phase_s;
      byte_r         <= byte_s;
      bp_lo_r        <= bp_lo_s;
      bp_pc_r        <= bp_pc_s;
      bp_en_r        <= bp_en_s;
      step_cnt_r     <= step_cnt_s;
      step_tgt_r     <= step_tgt_s;
      wd_cnt_r       <= wd_cnt_s;
      rd_uart        <= (state_s == S_GOT);
      pipeline_clk   <= (state_s == S_PULSE_HI);
      pipeline_reset <= preset_s;
      send_data      <= (state_s == S_SEND);
      stop_reason    <= reason_s;
      busy           <= (state_s != S_IDLE);
    end
  end

endmodule

// File: tb/tb_debug_rx_ctrl.sv
// Directed bench for debug_rx_ctrl. A tiny pipeline model advances pc on
// every pipeline_clk rising edge (clearing it while pipeline_reset is high)
// and raises program_finished once pc reaches fin_pc.
module tb_debug_rx_ctrl;

  logic       clk;
  logic       global_reset;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic       program_finished;
  logic [9:0] pc_in;
  logic       pipeline_clk;
  logic       pipeline_reset;
  logic       send_data;
  logic       data_sent;
  logic [1:0] stop_reason;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  int sends    = 0;
  int rds      = 0;

  logic [9:0] pc = 10'd0;
  logic       fin_en = 1'b0;
  logic [9:0] fin_pc = 10'd0;

  debug_rx_ctrl #(
    .CMD_W(8), .PC_W(10), .RUN_LIMIT_W(4), .RST_PULSES(2)
  ) dut (
    .clk(clk),
    .global_reset(global_reset),
    .r_data(r_data),
    .rx_empty(rx_empty),
    .rd_uart(rd_uart),
    .program_finished(program_finished),
    .pc_in(pc_in),
    .pipeline_clk(pipeline_clk),
    .pipeline_reset(pipeline_reset),
    .send_data(send_data),
    .data_sent(data_sent),
    .stop_reason(stop_reason),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign pc_in            = pc;
  assign program_finished = fin_en & (pc >= fin_pc);

  always @(posedge pipeline_clk) begin
    edges = edges + 1;
    if (pipeline_reset) pc <= 10'd0;
    else                pc <= pc + 10'd1;
  end

  always @(posedge clk) begin
    if (send_data === 1'b1) sends = sends + 1;
    if (rd_uart === 1'b1)   rds   = rds + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    r_data   = b;
    rx_empty = 1'b0;
    @(negedge clk);
    chk($sformatf("rd_uart_%02h", b), {31'd0, rd_uart}, 32'd1);
    rx_empty = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_send(input string tag, input int maxc);
    int n = 0;
    while (send_data !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_send_seen"}, {31'd0, send_data}, 32'd1);
  endtask

  task automatic finish_send(input string tag);
    @(negedge clk);
    chk({tag, "_send_one_cycle"}, {31'd0, send_data}, 32'd0);
    data_sent = 1'b1;
    @(negedge clk);
    data_sent = 1'b0;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic reset_release(input string tag);
    int n = 0;
    int e0 = edges;
    int s0 = sends;
    global_reset = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0) break;
    end
    chk({tag, "_rst_cycles"}, n, 32'd5);
    chk({tag, "_prst_low"}, {31'd0, pipeline_reset}, 32'd0);
    chk({tag, "_rst_pulses"}, edges - e0, 32'd2);
    chk({tag, "_no_send"}, sends - s0, 32'd0);
  endtask

  initial begin
    int e0;
    int s0;
    int r0;
    global_reset = 1'b1;
    r_data       = 8'h00;
    rx_empty     = 1'b1;
    data_sent    = 1'b0;

    // Power-up reset values, then the automatic reset sequence.
    @(negedge clk);
    chk("rst_pclk", {31'd0, pipeline_clk}, 32'd0);
    chk("rst_prst", {31'd0, pipeline_reset}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_send", {31'd0, send_data}, 32'd0);
    chk("rst_rd", {31'd0, rd_uart}, 32'd0);
    chk("rst_reason", {30'd0, stop_reason}, 32'd0);
    @(negedge clk);
    reset_release("pwr");
    chk("pwr_pc", {22'd0, pc}, 32'd0);

    // STEP with cycle-exact timing.
    e0 = edges; s0 = sends;
    r_data = 8'h01; rx_empty = 1'b0;
    @(negedge clk);
    chk("step_rd_t1", {31'd0, rd_uart}, 32'd1);
    chk("step_pclk_t1", {31'd0, pipeline_clk}, 32'd0);
    rx_empty = 1'b1;
    @(negedge clk);
    chk("step_pclk_t2", {31'd0, pipeline_clk}, 32'd1);
    chk("step_rd_t2", {31'd0, rd_uart}, 32'd0);
    @(negedge clk);
    chk("step_pclk_t3", {31'd0, pipeline_clk}, 32'd0);
    chk("step_send_t3", {31'd0, send_data}, 32'd0);
    @(negedge clk);
    chk("step_send_t4", {31'd0, send_data}, 32'd1);
    chk("step_reason", {30'd0, stop_reason}, 32'd0);
    @(negedge clk);
    chk("step_send_t5", {31'd0, send_data}, 32'd0);
    @(negedge clk);
    chk("step_busy_wait", {31'd0, busy}, 32'd1);
    data_sent = 1'b1;
    @(negedge clk);
    data_sent = 1'b0;
    chk("step_idle", {31'd0, busy}, 32'd0);
    chk("step_edges", edges - e0, 32'd1);
    chk("step_sends", sends - s0, 32'd1);

    // STEP_N 5, then STEP_N 0.
    e0 = edges; s0 = sends;
    send_byte(8'h04); send_byte(8'h05);
    wait_send("stepn5", 40);
    chk("stepn5_reason", {30'd0, stop_reason}, 32'd0);
    finish_send("stepn5");
    chk("stepn5_edges", edges - e0, 32'd5);
    chk("stepn5_sends", sends - s0, 32'd1);
    e0 = edges;
    send_byte(8'h04); send_byte(8'h00);
    wait_send("stepn0", 10);
    finish_send("stepn0");
    chk("stepn0_edges", edges - e0, 32'd0);
    chk("pc_after_steps", {22'd0, pc}, 32'd6);

    // SET_BP 12, RESET command, RUN until breakpoint.
    send_byte(8'h05); send_byte(8'h0C); send_byte(8'h00);
    wait_send("setbp", 10);
    finish_send("setbp");
    e0 = edges;
    send_byte(8'h03);
    wait_send("rstcmd", 20);
    chk("rstcmd_reason", {30'd0, stop_reason}, 32'd0);
    chk("rstcmd_prst", {31'd0, pipeline_reset}, 32'd0);
    finish_send("rstcmd");
    chk("rstcmd_edges", edges - e0, 32'd2);
    chk("rstcmd_pc", {22'd0, pc}, 32'd0);
    e0 = edges;
    send_byte(8'h02);
    wait_send("bp_run", 60);
    chk("bp_reason", {30'd0, stop_reason}, 32'd2);
    finish_send("bp_run");
    chk("bp_edges", edges - e0, 32'd12);
    chk("bp_pc", {22'd0, pc}, 32'd12);

    // CLR_BP, RESET, RUN runs past 12 into the watchdog (15 pulses).
    send_byte(8'h06);
    wait_send("clrbp", 10);
    chk("clrbp_reason", {30'd0, stop_reason}, 32'd0);
    finish_send("clrbp");
    send_byte(8'h03);
    wait_send("rst2", 20);
    finish_send("rst2");
    e0 = edges;
    send_byte(8'h02);
    wait_send("wd_run", 60);
    chk("wd_reason", {30'd0, stop_reason}, 32'd3);
    finish_send("wd_run");
    chk("wd_edges", edges - e0, 32'd15);
    chk("wd_pc", {22'd0, pc}, 32'd15);

    // Program finishes after pulse 7; then finished already high at start.
    send_byte(8'h03);
    wait_send("rst3", 20);
    finish_send("rst3");
    fin_en = 1'b1; fin_pc = 10'd7;
    e0 = edges;
    send_byte(8'h02);
    wait_send("fin_run", 40);
    chk("fin_reason", {30'd0, stop_reason}, 32'd1);
    finish_send("fin_run");
    chk("fin_edges", edges - e0, 32'd7);
    fin_pc = 10'd0;
    e0 = edges;
    send_byte(8'h02);
    wait_send("fin0_run", 20);
    chk("fin0_reason", {30'd0, stop_reason}, 32'd1);
    finish_send("fin0_run");
    chk("fin0_edges", edges - e0, 32'd1);
    fin_en = 1'b0;

    // global_reset in the middle of a RUN.
    send_byte(8'h02);
    repeat (6) @(negedge clk);
    global_reset = 1'b1;
    @(negedge clk);
    chk("abort_pclk", {31'd0, pipeline_clk}, 32'd0);
    chk("abort_prst", {31'd0, pipeline_reset}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_send", {31'd0, send_data}, 32'd0);
    chk("abort_reason", {30'd0, stop_reason}, 32'd0);
    reset_release("abort");

    // Unknown byte: popped and dropped.
    e0 = edges; s0 = sends;
    send_byte(8'hAA);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("unk_sends", sends - s0, 32'd0);
    chk("unk_edges", edges - e0, 32'd0);

    // Pending byte and stray data_sent while busy are ignored.
    e0 = edges; s0 = sends;
    send_byte(8'h04); send_byte(8'h08);
    r0 = rds;
    r_data = 8'h01; rx_empty = 1'b0;
    repeat (5) @(negedge clk);
    data_sent = 1'b1;
    @(negedge clk);
    data_sent = 1'b0;
    chk("busy_ignores_ds", {31'd0, busy}, 32'd1);
    wait_send("stepn8", 40);
    rx_empty = 1'b1;
    chk("busy_no_rd", rds - r0, 32'd0);
    finish_send("stepn8");
    chk("stepn8_edges", edges - e0, 32'd8);
    chk("stepn8_sends", sends - s0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
